// File: rtl/qam16_tx_mapper.sv
// ----------------------------------------------------------------------------
// qam16_tx_mapper
//   Transmit-side QAM-16 symbol mapper. Bytes arrive over a valid/ready
//   handshake. Each byte becomes two 4-bit symbols, high nibble first. Each
//   symbol is Gray-mapped to signed I/Q levels of -3A, -1A, +1A or +3A, and
//   the level is held for SPS clocks. A one-clock strobe marks mid-symbol and
//   starts the receiver's sampling.
//
//   Optional feature macro: QAM16_PREAMBLE_EN
//     When this macro is defined, every transmission that starts from IDLE is
//     preceded by PRE_LEN preamble symbols. The preamble alternates
//     (+3A,+3A) and (-3A,-3A) and starts with the positive symbol.
//     Back-to-back bytes do not get a preamble.
//
// Ports
//   clk         in   1      clock
//   rst_n       in   1      asynchronous reset, active-low
//   data_in     in   8      byte to transmit
//   data_valid  in   1      data_in valid
//   data_ready  out  1      byte accepted this cycle when data_valid is high
//   i_out       out  WIDTH  in-phase level, signed, registered
//   q_out       out  WIDTH  quadrature level, signed, registered
//   out_valid   out  1      i_out/q_out carry a symbol, registered
//   sym_strobe  out  1      one-clock pulse at mid-symbol, registered
//   busy        out  1      mapper is not idle, registered
// ----------------------------------------------------------------------------
module qam16_tx_mapper #(
    parameter int WIDTH   = 16,
    parameter int SPS     = 8,
    parameter int AMP     = 4096,
    parameter int PRE_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    out_valid,
    output logic                    sym_strobe,
    output logic                    busy
);

    localparam int CW = $clog2(SPS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(SPS / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic signed [WIDTH-1:0] LVL_P3 = WIDTH'(3 * AMP);
    localparam logic signed [WIDTH-1:0] LVL_P1 = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] LVL_N1 = WIDTH'(-AMP);
    localparam logic signed [WIDTH-1:0] LVL_N3 = WIDTH'(-3 * AMP);

    // Elaboration-time parameter sanity checks
    if (SPS < 4 || (SPS % 2) != 0) begin : g_bad_sps
        $error("qam16_tx_mapper: SPS must be even and >= 4");
    end
    if (PRE_LEN < 1) begin : g_bad_pre
        $error("qam16_tx_mapper: PRE_LEN must be >= 1");
    end
    if ((3 * AMP) >= (1 << (WIDTH - 1))) begin : g_bad_amp
        $error("qam16_tx_mapper: 3*AMP does not fit in signed WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYM_HI = 2'd1,
        SYM_LO = 2'd2,
        PRE    = 2'd3
    } state_t;

    // Gray-coded bit pair to signed level: 00->-3A, 01->-1A, 11->+1A, 10->+3A
    function automatic logic signed [WIDTH-1:0] gray_level(input logic [1:0] g);
        logic signed [WIDTH-1:0] lvl;
        case (g)
            2'b00:   lvl = LVL_N3;
            2'b01:   lvl = LVL_N1;
            2'b11:   lvl = LVL_P1;
            2'b10:   lvl = LVL_P3;
            default: lvl = '0;
        endcase
        return lvl;
    endfunction

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic [3:0]              lo_nib_r, lo_nib_s;
    logic signed [WIDTH-1:0] i_s, q_s;
    logic                    valid_s, strobe_s, accept_s;

`ifdef QAM16_PREAMBLE_EN
    localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    logic [PW-1:0] pre_cnt_r, pre_cnt_s;
    // High nibble must survive the preamble, so it is kept as well
    logic [3:0]    hi_nib_r, hi_nib_s;
`endif

    // Ready is combinational from state so a new byte can be taken on the
    // last SYM_LO clock without a gap; forced low while reset is asserted
    assign data_ready = rst_n & ((state_r == IDLE) |
                                 ((state_r == SYM_LO) & (cnt_r == CNT_LAST)));
    assign accept_s   = data_valid & data_ready;

    // Next-state, counter and next-output computation
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        lo_nib_s = lo_nib_r;
        i_s      = i_out;
        q_s      = q_out;
`ifdef QAM16_PREAMBLE_EN
        pre_cnt_s = pre_cnt_r;
        hi_nib_s  = hi_nib_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_s    = '0;
                    lo_nib_s = data_in[3:0];
`ifdef QAM16_PREAMBLE_EN
                    hi_nib_s  = data_in[7:4];
                    pre_cnt_s = '0;
                    state_s   = PRE;
                    i_s       = LVL_P3;
                    q_s       = LVL_P3;
`else
                    state_s = SYM_HI;
                    i_s     = gray_level(data_in[7:6]);
                    q_s     = gray_level(data_in[5:4]);
`endif
                end else begin
                    i_s = '0;
                    q_s = '0;
                end
            end
`ifdef QAM16_PREAMBLE_EN
            PRE: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (pre_cnt_r == PRE_LAST) begin
                        state_s = SYM_HI;
                        i_s     = gray_level(hi_nib_r[3:2]);
                        q_s     = gray_level(hi_nib_r[1:0]);
                    end else begin
                        // Even preamble index is positive, odd is negative
                        pre_cnt_s = pre_cnt_r + PRE_ONE;
                        i_s       = pre_cnt_r[0] ? LVL_P3 : LVL_N3;
                        q_s       = pre_cnt_r[0] ? LVL_P3 : LVL_N3;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            SYM_HI: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    state_s = SYM_LO;
                    i_s     = gray_level(lo_nib_r[3:2]);
                    q_s     = gray_level(lo_nib_r[1:0]);
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            SYM_LO: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (accept_s) begin
                        // Back-to-back byte: no preamble, no gap
                        state_s  = SYM_HI;
                        lo_nib_s = data_in[3:0];
`ifdef QAM16_PREAMBLE_EN
                        hi_nib_s = data_in[7:4];
`endif
                        i_s      = gray_level(data_in[7:6]);
                        q_s      = gray_level(data_in[5:4]);
                    end else begin
                        state_s = IDLE;
                        i_s     = '0;
                        q_s     = '0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                i_s     = '0;
                q_s     = '0;
            end
        endcase
        valid_s  = (state_s != IDLE);
        strobe_s = valid_s && (cnt_s == CNT_MID);
    end

    // State, counter, latched byte and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            lo_nib_r   <= 4'h0;
            i_out      <= '0;
            q_out      <= '0;
            out_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
`ifdef QAM16_PREAMBLE_EN
            pre_cnt_r  <= '0;
            hi_nib_r   <= 4'h0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            lo_nib_r   <= lo_nib_s;
            i_out      <= i_s;
            q_out      <= q_s;
            out_valid  <= valid_s;
            sym_strobe <= strobe_s;
            busy       <= valid_s;
`ifdef QAM16_PREAMBLE_EN
            pre_cnt_r  <= pre_cnt_s;
            hi_nib_r   <= hi_nib_s;
`endif
        end
    end

endmodule

// File: tb/tb_qam16_tx_mapper.sv
// ----------------------------------------------------------------------------
// tb_qam16_tx_mapper
//   Self-checking bench for qam16_tx_mapper. It uses a table of hand-computed
//   byte/level vectors, directed back-to-back and reset sequences, and a
//   randomized handshake run. A queue-based reference model of the expected
//   per-clock output stream checks every clock.
// ----------------------------------------------------------------------------
module tb_qam16_tx_mapper;

    localparam int WIDTH   = 16;
    localparam int SPS     = 8;
    localparam int AMP     = 4096;
    localparam int PRE_LEN = 4;
`ifdef QAM16_PREAMBLE_EN
    localparam int PRE_CYC = PRE_LEN * SPS;
    localparam int PRE_SYM = PRE_LEN;
`else
    localparam int PRE_CYC = 0;
    localparam int PRE_SYM = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [7:0]              data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic signed [WIDTH-1:0] i_out;
    logic signed [WIDTH-1:0] q_out;
    logic                    out_valid;
    logic                    sym_strobe;
    logic                    busy;

    qam16_tx_mapper #(
        .WIDTH(WIDTH), .SPS(SPS), .AMP(AMP), .PRE_LEN(PRE_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .sym_strobe(sym_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected content of one output clock
    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic               stb;
    } samp_t;

    typedef struct {
        logic [7:0]         b;
        logic signed [15:0] hi_i, hi_q, lo_i, lo_q;
    } vec_t;

    samp_t exp_q[$];
    vec_t  tbl[6];
    int    n_pass = 0, n_chk = 0;
    int    cnt_valid = 0, cnt_stb = 0;
    logic  last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] dut_vec();
        return {28'd0, data_ready, out_valid, sym_strobe, busy, i_out, q_out};
    endfunction

    // Gray pair -> level: Gray-to-binary index 0..3 -> (2*idx-3)*A
    function automatic logic signed [15:0] lvl(input logic [1:0] g);
        int idx;
        idx = 2 * int'(g[1]) + int'(g[1] ^ g[0]);
        return 16'((2 * idx - 3) * AMP);
    endfunction

    // Push the expected clocks of one byte (plus preamble when started from idle)
    task automatic push_byte(input logic [7:0] b, input bit from_idle);
        samp_t s;
        logic [3:0] nib;
        if (from_idle) begin
            for (int p = 0; p < PRE_SYM; p++)
                for (int k = 0; k < SPS; k++) begin
                    s.i = (p % 2 == 0) ? 16'(3 * AMP) : 16'(-3 * AMP);
                    s.q = s.i;
                    s.stb = (k == SPS / 2);
                    exp_q.push_back(s);
                end
        end
        for (int n = 0; n < 2; n++) begin
            nib = (n == 0) ? b[7:4] : b[3:0];
            for (int k = 0; k < SPS; k++) begin
                s.i = lvl(nib[3:2]);
                s.q = lvl(nib[1:0]);
                s.stb = (k == SPS / 2);
                exp_q.push_back(s);
            end
        end
    endtask

    // One clock: drive inputs, compare the whole output vector against the
    // model, then advance the model across the rising edge
    task automatic run_cycle(input logic v, input logic [7:0] b, input string name);
        logic  m_ready, m_act, acc;
        samp_t s;
        @(negedge clk);
        data_valid = v;
        data_in    = b;
        m_act   = (exp_q.size() > 0);
        m_ready = (exp_q.size() <= 1);
        s = m_act ? exp_q[0] : samp_t'('0);
        chk(name, dut_vec(), {28'd0, m_ready, m_act, s.stb, m_act, s.i, s.q});
        cnt_valid += int'(out_valid);
        cnt_stb   += int'(sym_strobe);
        acc = v && m_ready;
        last_acc = acc;
        @(posedge clk);
        if (m_act) void'(exp_q.pop_front());
        if (acc) push_byte(b, !m_act);
    endtask

    initial begin
        bit         hold;
        logic [7:0] cur;
        int         waited;

        tbl[0] = '{8'hB4,  16'sd12288,  16'sd4096,  -16'sd4096, -16'sd12288};
        tbl[1] = '{8'h00, -16'sd12288, -16'sd12288, -16'sd12288, -16'sd12288};
        tbl[2] = '{8'hFF,  16'sd4096,   16'sd4096,   16'sd4096,   16'sd4096};
        tbl[3] = '{8'h5A, -16'sd4096,  -16'sd4096,   16'sd12288,  16'sd12288};
        tbl[4] = '{8'hA5,  16'sd12288,  16'sd12288, -16'sd4096,  -16'sd4096};
        tbl[5] = '{8'h36, -16'sd12288,  16'sd4096,  -16'sd4096,   16'sd12288};

        // Reset state
        rst_n = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        #12;
        chk("reset_state", dut_vec(), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Table-driven single bytes from idle
        for (int t = 0; t < 6; t++) begin
            run_cycle(1'b1, tbl[t].b, "tbl_accept");
            repeat (PRE_CYC) run_cycle(1'b0, 8'($urandom), "tbl_pre");
            #1 chk("tbl_hi", {32'd0, i_out, q_out}, {32'd0, tbl[t].hi_i, tbl[t].hi_q});
            repeat (SPS) run_cycle(1'b0, 8'($urandom), "tbl_cycle");
            #1 chk("tbl_lo", {32'd0, i_out, q_out}, {32'd0, tbl[t].lo_i, tbl[t].lo_q});
            repeat (SPS) run_cycle(1'b0, 8'($urandom), "tbl_cycle");
            #1 chk("tbl_idle", {31'd0, out_valid, i_out, q_out}, 64'd0);
        end

        // Back-to-back 0x00, 0xFF held valid: contiguous output, no gap
        cnt_valid = 0; cnt_stb = 0;
        run_cycle(1'b1, 8'h00, "b2b_first");
        waited = 0;
        do begin
            run_cycle(1'b1, 8'hFF, "b2b_hold");
            waited++;
        end while (!last_acc && waited < 40);
        chk("b2b_hold_clocks", 64'(waited), 64'(2 * SPS + PRE_CYC));
        repeat (2 * SPS + 2) run_cycle(1'b0, 8'($urandom), "b2b_drain");
        chk("b2b_valid_clocks", 64'(cnt_valid), 64'(4 * SPS + PRE_CYC));
        chk("b2b_strobes", 64'(cnt_stb), 64'(4 + PRE_SYM));

        // Reset during the fourth clock of the first symbol
        run_cycle(1'b1, 8'h3C, "rst_accept");
        repeat (3) run_cycle(1'b0, 8'($urandom), "rst_pre_cycle");
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_symbol", dut_vec(), 64'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (3 * SPS) run_cycle(1'b0, 8'($urandom), "rst_no_resume");

        // Randomized handshake: sender holds a byte until it is taken
        hold = 1'b0; cur = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            if (!hold && $urandom_range(0, 3) != 0) begin
                hold = 1'b1;
                cur  = 8'($urandom);
            end
            run_cycle(hold, hold ? cur : 8'($urandom), "rand");
            if (last_acc) hold = 1'b0;
        end
        repeat (2 * SPS + PRE_CYC + 2) run_cycle(1'b0, 8'($urandom), "rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
